// File: rtl/decoder_arbiter_pkg.sv
// decoder_arbiter_pkg: shared widths, requester index type and reset grant state
package decoder_arbiter_pkg;
  localparam int CODE_W = 3;
  localparam int DATA_W = 4;
  typedef logic req_idx_t;
  localparam req_idx_t RST_LAST_GRANT = 1'b1;
endpackage

// File: rtl/decoder.sv
// decoder: combinational 3-to-4 code lookup
module decoder
  import decoder_arbiter_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data
);
  always_comb
    case (code)
      3'd0:    data = 4'b0100;
      3'd1:    data = 4'b1010;
      3'd2:    data = 4'b0111;
      3'd3:    data = 4'b1100;
      3'd4:    data = 4'b1001;
      3'd5:    data = 4'b1101;
      3'd6:    data = 4'b0000;
      default: data = 4'b0010;
    endcase
endmodule

// File: rtl/decoder_arbiter.sv
// decoder_arbiter: round-robin sharing of one decoder between two valid/ready requesters
module decoder_arbiter
  import decoder_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [CODE_W-1:0] req0_code,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CODE_W-1:0] req1_code,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt,
  output logic              busy
);
  req_idx_t          last_grant;
  logic              elig0, elig1, grant0, grant1;
  logic [CODE_W-1:0] dec_code;
  logic [DATA_W-1:0] dec_data;
  // a slot draining this cycle may be refilled this cycle
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);
  assign grant0 = elig0 & (~elig1 | last_grant);
  assign grant1 = elig1 & (~elig0 | ~last_grant);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign dec_code = grant1 ? req1_code : req0_code;
  assign busy = rsp0_valid | rsp1_valid;
  decoder u_decoder (
    .code (dec_code),
    .data (dec_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant <= RST_LAST_GRANT;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      last_grant <= grant1 ? 1'b1 : grant0 ? 1'b0 : last_grant;
      rsp0_valid <= grant0 | (rsp0_valid & ~rsp0_ready);
      rsp1_valid <= grant1 | (rsp1_valid & ~rsp1_ready);
      rsp0_data  <= grant0 ? dec_data : rsp0_data;
      rsp1_data  <= grant1 ? dec_data : rsp1_data;
      grant0_cnt <= grant0_cnt + CNT_W'(grant0);
      grant1_cnt <= grant1_cnt + CNT_W'(grant1);
    end
endmodule

// File: tb/tb_decoder_arbiter.sv
// tb_decoder_arbiter: directed and random checks of decoder_arbiter against a behavioural model
module tb_decoder_arbiter;
  logic       clk = 0, rst_n = 1;
  logic       req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [2:0] req0_code = 0, req1_code = 0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic       w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_busy;
  logic [3:0] rsp0_data, rsp1_data, w_rsp0_data, w_rsp1_data;
  logic [7:0] grant0_cnt, grant1_cnt;
  logic [1:0] w_grant0_cnt, w_grant1_cnt;
  int tests = 0, fails = 0;
  logic [3:0] lut [8] = '{4'b0100, 4'b1010, 4'b0111, 4'b1100, 4'b1001, 4'b1101, 4'b0000, 4'b0010};
  bit         m_last = 1;
  bit         m_v [2] = '{0, 0};
  logic [3:0] m_d [2] = '{0, 0};
  int         m_cnt [2] = '{0, 0};
  logic [31:0] table_lit = 32'h4A7C_9D02;

  decoder_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .busy(busy)
  );
  decoder_arbiter #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(w_req0_ready),
    .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(w_req1_ready),
    .rsp0_valid(w_rsp0_valid), .rsp0_data(w_rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(w_rsp1_valid), .rsp1_data(w_rsp1_data), .rsp1_ready(rsp1_ready),
    .grant0_cnt(w_grant0_cnt), .grant1_cnt(w_grant1_cnt), .busy(w_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_grant();
    bit e [2];
    e[0] = req0_valid && (!m_v[0] || rsp0_ready);
    e[1] = req1_valid && (!m_v[1] || rsp1_ready);
    if (e[0] && e[1]) return m_last ? 2'b01 : 2'b10;
    return {e[1], e[0]};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_last = 1;
      m_v = '{0, 0};
      m_d = '{0, 0};
      m_cnt = '{0, 0};
    end else begin
      logic [1:0] g;
      logic [2:0] c [2];
      logic       r [2];
      g = exp_grant();
      c = '{req0_code, req1_code};
      r = '{rsp0_ready, rsp1_ready};
      for (int i = 0; i < 2; i++)
        if (g[i]) begin
          m_v[i] = 1;
          m_d[i] = lut[c[i]];
          m_cnt[i]++;
          m_last = i[0];
        end else if (r[i]) m_v[i] = 0;
    end

  always @(negedge clk) begin
    logic [1:0] g;
    g = exp_grant();
    chk("req0_ready", req0_ready, g[0]);
    chk("req1_ready", req1_ready, g[1]);
    chk("rsp0_valid", rsp0_valid, m_v[0]);
    chk("rsp1_valid", rsp1_valid, m_v[1]);
    chk("rsp0_data", rsp0_data, m_d[0]);
    chk("rsp1_data", rsp1_data, m_d[1]);
    chk("grant0_cnt", grant0_cnt, m_cnt[0] % 256);
    chk("grant1_cnt", grant1_cnt, m_cnt[1] % 256);
    chk("w2_grant0_cnt", w_grant0_cnt, m_cnt[0] % 4);
    chk("w2_grant1_cnt", w_grant1_cnt, m_cnt[1] % 4);
    chk("busy", busy, m_v[0] | m_v[1]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp_data", {rsp0_data, rsp1_data}, 0);
    chk("rst_cnt", {grant0_cnt, grant1_cnt}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", {req0_ready, req1_ready}, 0);
    tick();
    tick();
    rst_n = 1;
    // tie alternation: requester 0 wins first after reset
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = 4'b1111;
    req0_code = 3'b101;
    req1_code = 3'b101;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("tie_grant0", req0_ready, (i % 2) == 0);
      chk("tie_grant1", req1_ready, (i % 2) == 1);
      tick();
    end
    chk("tie_rsp0", rsp0_data, 4'b1101);
    chk("tie_rsp1", rsp1_data, 4'b1101);
    chk("tie_cnt0", grant0_cnt, 3);
    chk("tie_cnt1", grant1_cnt, 3);
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = 4'b1000;
    tick();
    req0_valid = 0;
    #1;
    chk("full_before_rst", {rsp0_valid, rsp1_valid}, 2'b11);
    rst_n = 0;
    #1;
    chk("midrst_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("midrst_data", {rsp0_data, rsp1_data}, 0);
    chk("midrst_cnt", {grant0_cnt, grant1_cnt}, 0);
    chk("midrst_busy", busy, 0);
    tick();
    rst_n = 1;
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = 4'b1111;
    #1;
    chk("post_rst_tie", {req1_ready, req0_ready}, 2'b01);
    // exhaustive table through requester 0
    req1_valid = 0;
    for (int c = 0; c < 8; c++) begin
      req0_code = c[2:0];
      #1;
      chk("exh_ready", req0_ready, 1);
      tick();
      chk("exh_data", rsp0_data, table_lit[31-4*c -: 4]);
    end
    req0_valid = 0;
    #1;
    chk("exh_cnt0", grant0_cnt, 8);
    chk("exh_cnt0_w2", w_grant0_cnt, 0);
    // backpressure on requester 1
    req1_valid = 1;
    req1_code = 3'b010;
    rsp1_ready = 0;
    tick();
    chk("bp_fill", {rsp1_valid, rsp1_data}, 5'b10111);
    req1_code = 3'b110;
    req0_valid = 1;
    rsp0_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req0_code = 3'($urandom);
      #1;
      chk("bp_req1_blocked", req1_ready, 0);
      chk("bp_req0_stream", req0_ready, 1);
      tick();
      chk("bp_rsp1_stable", rsp1_data, 4'b0111);
    end
    rsp1_ready = 1;
    #1;
    chk("bp_release", {req1_ready, req0_ready}, 2'b10);
    tick();
    chk("bp_new_data", rsp1_data, 4'b0000);
    // same-cycle drain and refill
    req1_valid = 0;
    req0_code = 3'b000;
    rsp0_ready = 0;
    tick();
    chk("dr_fill", rsp0_data, 4'b0100);
    req0_code = 3'b111;
    rsp0_ready = 1;
    #1;
    chk("dr_ready", req0_ready, 1);
    tick();
    chk("dr_valid", rsp0_valid, 1);
    chk("dr_data", rsp0_data, 4'b0010);
    // counter wrap on the narrow instance
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) tick();
    req0_valid = 0;
    #1;
    chk("wrap_w2", w_grant0_cnt, 1);
    chk("wrap_w8", grant0_cnt, 5);
    for (int i = 0; i < 400; i++) begin
      tick();
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      req0_code = 3'($urandom);
      req1_code = 3'($urandom);
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 2) == 0;
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
